// File: rtl/serial_mod_arbiter_if.sv
// serial_mod_arbiter_if: requester, result and status signals of the shared mod-DIVISOR engine
interface serial_mod_arbiter_if #(
   parameter int WIDTH = 8,
   parameter int RES_W = 4
);
   logic             req0_valid, req0_ready, req1_valid, req1_ready;
   logic [WIDTH-1:0] req0_data, req1_data;
   logic             res_valid, res_ready, res_div, res_id, busy;
   logic [RES_W-1:0] res_rem;
   modport slave (
      input  req0_valid, req0_data, req1_valid, req1_data, res_ready,
      output req0_ready, req1_ready, res_valid, res_rem, res_div, res_id, busy
   );
   modport master (
      output req0_valid, req0_data, req1_valid, req1_data, res_ready,
      input  req0_ready, req1_ready, res_valid, res_rem, res_div, res_id, busy
   );
endinterface

// File: rtl/serial_mod_arbiter.sv
// serial_mod_arbiter: round-robin share of one bit-serial mod-DIVISOR residue engine between two requesters.
// Optional SERIAL_MOD_ZERO_SKIP_EN: zero words go straight to DONE without shifting.
module serial_mod_arbiter #(
   parameter int WIDTH   = 8,
   parameter int DIVISOR = 5,
   parameter int RES_W   = 4
) (
   input logic                clk,
   input logic                rst,
   serial_mod_arbiter_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   if (WIDTH < 2 || DIVISOR < 2 || DIVISOR > 2**RES_W - 1) begin : g_bad_param
      $error("serial_mod_arbiter: illegal WIDTH/DIVISOR/RES_W");
   end

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] sh_q;
   logic [RES_W-1:0] res_q, rem_q;
   logic [CW-1:0]    cnt_q;
   logic             last_q, id_q, div_q, valid_q;
   logic             grant, accept;
   logic [WIDTH-1:0] data_sel;
   logic [RES_W:0]   t_d;
   logic [RES_W-1:0] res_d;

   always_comb begin
      grant    = (bus.req0_valid && bus.req1_valid) ? ~last_q : bus.req1_valid;
      accept   = (state_q == IDLE) && !rst && (bus.req0_valid || bus.req1_valid);
      data_sel = grant ? bus.req1_data : bus.req0_data;
      t_d      = {res_q, sh_q[WIDTH-1]};
      // residue < DIVISOR keeps t below 2*DIVISOR, so one conditional subtract suffices
      res_d    = RES_W'(t_d >= (RES_W+1)'(DIVISOR) ? t_d - (RES_W+1)'(DIVISOR) : t_d);
   end

   assign bus.req0_ready = accept && !grant;
   assign bus.req1_ready = accept && grant;
   assign bus.res_valid  = valid_q;
   assign bus.res_rem    = rem_q;
   assign bus.res_div    = div_q;
   assign bus.res_id     = id_q;
   assign bus.busy       = state_q != IDLE;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sh_q    <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         last_q  <= 1'b1;
         id_q    <= 1'b0;
         rem_q   <= '0;
         div_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (accept) begin
               sh_q   <= data_sel;
               res_q  <= '0;
               cnt_q  <= '0;
               id_q   <= grant;
               last_q <= grant;
`ifdef SERIAL_MOD_ZERO_SKIP_EN
               if (data_sel == '0) begin
                  rem_q   <= '0;
                  div_q   <= 1'b1;
                  valid_q <= 1'b1;
                  state_q <= DONE;
               end else begin
                  state_q <= SHIFT;
               end
`else
               state_q <= SHIFT;
`endif
            end
            SHIFT: begin
               res_q <= res_d;
               sh_q  <= {sh_q[WIDTH-2:0], 1'b0};
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) begin
                  rem_q   <= res_d;
                  div_q   <= res_d == '0;
                  valid_q <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: if (bus.res_ready) begin
               valid_q <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
